// File: rtl/xbus_pkg.sv
// Shared types and encodings for the external byte-bus controller and its
// wait counter.
package xbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_HOLD,
        ST_TURN
    } xbus_state_t;

    localparam logic DIR_A2B   = 1'b1;
    localparam logic DIR_B2A   = 1'b0;
    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    // Wide enough for the largest ACTIVE extension (15) and TURN length (7).
    localparam int CTR_W = 4;

endpackage

// File: rtl/xbus_wait_ctr.sv
// Loadable down-counter that times the ACTIVE and TURN phases; it saturates
// at zero so the controller can sit in a phase while zero stays asserted.
module xbus_wait_ctr
    import xbus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CTR_W-1:0] value,
    output logic             zero
);

    logic [CTR_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/xbus_ctrl.sv
// Sequences CPU byte/word accesses onto an 8-bit external bus through one
// SN74LVC245 transceiver (A = local side, B = memory side).
module xbus_ctrl
    import xbus_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int TURN_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        size,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic [15:0] ext_addr,
    output logic        ext_rd_n,
    output logic        ext_wr_n,
    input  logic        ext_wait,
    output logic        xcvr_dir,
    output logic        xcvr_oe_n,
    output logic [7:0]  xcvr_a_out,
    output logic        xcvr_a_drv,
    input  logic [7:0]  xcvr_a_in,
    output xbus_state_t dbg_state
);

    // Handshake: req is sampled only while busy is low; that edge accepts the
    // access. ack pulses for exactly one cycle when the last byte finishes.
    xbus_state_t      state, state_nx;
    logic             we_q, size_q, idx;
    logic [15:0]      wdata_q;
    logic             ctr_load, ctr_zero;
    logic [CTR_W-1:0] ctr_value;
    logic             accept, active_done, turn_done, last_byte;

    xbus_wait_ctr u_ctr (
        .clk   (clk),
        .rst   (rst),
        .load  (ctr_load),
        .value (ctr_value),
        .zero  (ctr_zero)
    );

    assign last_byte = (size_q == SIZE_BYTE) || idx;

    always_comb begin
        state_nx    = state;
        ctr_load    = 1'b0;
        ctr_value   = '0;
        accept      = 1'b0;
        active_done = 1'b0;
        turn_done   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    accept   = 1'b1;
                    state_nx = ST_SETUP;
                end
            end
            ST_SETUP: begin
                ctr_load  = 1'b1;
                ctr_value = CTR_W'(WAIT_CYCLES);
                state_nx  = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // ext_wait only matters once the programmed wait has run out.
                if (ctr_zero && !ext_wait) begin
                    active_done = 1'b1;
                    state_nx    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                ctr_load  = 1'b1;
                ctr_value = CTR_W'(TURN_CYCLES - 1);
                state_nx  = ST_TURN;
            end
            ST_TURN: begin
                if (ctr_zero) begin
                    turn_done = 1'b1;
                    state_nx  = last_byte ? ST_IDLE : ST_SETUP;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            we_q     <= 1'b0;
            size_q   <= SIZE_BYTE;
            idx      <= 1'b0;
            wdata_q  <= '0;
            ext_addr <= '0;
            rdata    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q     <= we;
                size_q   <= size;
                wdata_q  <= wdata;
                ext_addr <= addr;
                idx      <= 1'b0;
            end
            if (turn_done && !last_byte) begin
                idx      <= 1'b1;
                ext_addr <= ext_addr + 16'd1;
            end
            if (active_done && !we_q) begin
                if (idx) begin
                    rdata[15:8] <= xcvr_a_in;
                end else begin
                    rdata[7:0] <= xcvr_a_in;
                    if (size_q == SIZE_BYTE) rdata[15:8] <= '0;
                end
            end
        end
    end

    // DIR comes straight from the latched we, so it only moves on acceptance,
    // when OE is already high.
    assign xcvr_dir   = we_q ? DIR_A2B : DIR_B2A;
    assign xcvr_oe_n  = !((state == ST_ACTIVE) || (state == ST_HOLD));
    assign ext_rd_n   = !((state == ST_ACTIVE) && !we_q);
    assign ext_wr_n   = !((state == ST_ACTIVE) && we_q);
    assign xcvr_a_drv = we_q && ((state == ST_SETUP) || (state == ST_ACTIVE) || (state == ST_HOLD));
    assign xcvr_a_out = idx ? wdata_q[15:8] : wdata_q[7:0];
    assign busy       = (state != ST_IDLE);
    assign ack        = turn_done && last_byte;
    assign dbg_state  = state;

endmodule

// File: tb/tb_xbus_ctrl.sv
// Bench for xbus_ctrl: behavioural 245 transceiver and 8-bit SRAM on the B side,
// directed scenarios followed by randomized accesses against a timeline model.
module tb_xbus_ctrl;
    import xbus_pkg::*;

    localparam int WAITC    = 1;
    localparam int TURNC    = 1;
    localparam int PH_SETUP = 1;
    localparam int PH_ACT   = 2;
    localparam int PH_HOLD  = 3;
    localparam int PH_TURN  = 4;

    logic        clk, rst, req, we, size, ext_wait;
    logic [15:0] addr, wdata, rdata, ext_addr;
    logic        ack, busy, ext_rd_n, ext_wr_n, xcvr_dir, xcvr_oe_n, xcvr_a_drv;
    logic [7:0]  xcvr_a_out, xcvr_a_in;
    xbus_state_t dbg_state;

    int          n_compared;
    int          n_mismatched;
    logic [15:0] exp_rdata;
    logic [7:0]  ref_mem [65536];
    logic [7:0]  sram [65536];

    logic        a_ctrl_on, a_xcvr_on, b_xcvr_on, b_sram_on;
    logic [7:0]  a_bus, b_bus;

    xbus_ctrl #(.WAIT_CYCLES(WAITC), .TURN_CYCLES(TURNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .size       (size),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ack        (ack),
        .busy       (busy),
        .ext_addr   (ext_addr),
        .ext_rd_n   (ext_rd_n),
        .ext_wr_n   (ext_wr_n),
        .ext_wait   (ext_wait),
        .xcvr_dir   (xcvr_dir),
        .xcvr_oe_n  (xcvr_oe_n),
        .xcvr_a_out (xcvr_a_out),
        .xcvr_a_drv (xcvr_a_drv),
        .xcvr_a_in  (xcvr_a_in),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #25 clk = ~clk;

    // ---------------- transceiver and bus resolution ----------------
    always_comb begin
        a_ctrl_on = (xcvr_a_drv == 1'b1);
        a_xcvr_on = (xcvr_oe_n == 1'b0) && (xcvr_dir == DIR_B2A);
        b_xcvr_on = (xcvr_oe_n == 1'b0) && (xcvr_dir == DIR_A2B);
        b_sram_on = (ext_rd_n == 1'b0);
        b_bus = 8'h00;
        if (b_xcvr_on && !b_sram_on && a_ctrl_on) b_bus = xcvr_a_out;
        else if (b_sram_on && !b_xcvr_on)         b_bus = sram[ext_addr];
        a_bus = 8'h00;
        if (a_ctrl_on && !a_xcvr_on)      a_bus = xcvr_a_out;
        else if (a_xcvr_on && !a_ctrl_on) a_bus = b_bus;
    end
    assign xcvr_a_in = a_bus;

    function automatic logic [7:0] init_byte(input int i);
        if (i == 32'h2000) return 8'h3C;
        if (i == 32'h2001) return 8'h7E;
        return 8'((i * 73) ^ (i >> 5) ^ 32'hA3);
    endfunction

    // SRAM: byte written on every clock edge with WE low.
    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (!rst && ext_wr_n == 1'b0) sram[ext_addr] <= b_bus;
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check1(input string tag, input logic obs, input logic want);
        n_compared++;
        assert (obs === want) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, want);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_compared++;
        assert (obs === want) else begin
            n_mismatched++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, want);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int want);
        n_compared++;
        assert (obs == want) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    // Bus invariants checked every cycle outside reset.
    task automatic monitor();
        logic prev_oe_n, prev_dir;
        prev_oe_n = 1'b1;
        prev_dir  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (!prev_oe_n && !xcvr_oe_n) check1("dir_stable_while_oe_low", xcvr_dir, prev_dir);
                check1("a_side_contention", a_ctrl_on && a_xcvr_on, 1'b0);
                check1("b_side_contention", b_xcvr_on && b_sram_on, 1'b0);
                check1("strobes_both_low", !ext_rd_n && !ext_wr_n, 1'b0);
                check1("a_drv_during_read", xcvr_a_drv && (xcvr_dir == DIR_B2A), 1'b0);
            end
            prev_oe_n = xcvr_oe_n;
            prev_dir  = xcvr_dir;
        end
    endtask

    // ---------------- driver + timeline model ----------------
    // One access: nw0/nw1 are the number of ext_wait stretches for byte 0/1.
    task automatic access(input logic w, input logic sz, input logic [15:0] a,
                          input logic [15:0] d, input int nw0, input int nw1,
                          output int ack_cyc);
        int          ph [64];
        int          pb [64];
        logic        ws [64];
        int          c, total, n, p, b;
        logic [15:0] a1;
        a1 = a + 16'd1;
        for (int i = 0; i < 64; i++) begin
            ph[i] = 0;
            pb[i] = 0;
            ws[i] = 1'($urandom_range(0, 1));
        end
        c = 1;
        for (int bi = 0; bi < (sz ? 2 : 1); bi++) begin
            n = (bi == 0) ? nw0 : nw1;
            ph[c] = PH_SETUP; pb[c] = bi; c++;
            for (int k = 0; k < 1 + WAITC + n; k++) begin
                ph[c] = PH_ACT; pb[c] = bi;
                if (k >= WAITC) ws[c] = (k < WAITC + n);
                c++;
            end
            ph[c] = PH_HOLD; pb[c] = bi; c++;
            for (int k = 0; k < TURNC; k++) begin
                ph[c] = PH_TURN; pb[c] = bi; c++;
            end
        end
        total = c - 1;

        if (w) begin
            ref_mem[a] = d[7:0];
            if (sz) ref_mem[a1] = d[15:8];
        end else begin
            exp_rdata = sz ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
        end

        @(negedge clk);
        req = 1'b1; we = w; size = sz; addr = a; wdata = d; ext_wait = 1'b0;
        @(posedge clk);
        ack_cyc = 0;
        for (int cc = 1; cc <= total; cc++) begin
            #1;
            ext_wait = ws[cc];
            req   = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            size  = 1'($urandom_range(0, 1));
            addr  = 16'($urandom);
            wdata = 16'($urandom);
            @(negedge clk);
            p = ph[cc];
            b = pb[cc];
            check1("busy", busy, 1'b1);
            check1("ack", ack, cc == total);
            check1("oe_n", xcvr_oe_n, !(p == PH_ACT || p == PH_HOLD));
            check1("rd_n", ext_rd_n, !(p == PH_ACT && !w));
            check1("wr_n", ext_wr_n, !(p == PH_ACT && w));
            check1("dir", xcvr_dir, w);
            check1("a_drv", xcvr_a_drv, w && (p != PH_TURN));
            if (p != PH_TURN) check16("ext_addr", ext_addr, (b != 0) ? a1 : a);
            if (w && p != PH_TURN)
                check16("a_out", {8'h00, xcvr_a_out}, (b != 0) ? {8'h00, d[15:8]} : {8'h00, d[7:0]});
            if (ack && ack_cyc == 0) ack_cyc = cc;
            @(posedge clk);
        end
        #1;
        req = 1'b0;
        ext_wait = 1'b0;
        #1;
        check1("idle_busy", busy, 1'b0);
        check1("idle_ack", ack, 1'b0);
        check1("idle_oe_n", xcvr_oe_n, 1'b1);
        check16("rdata", rdata, exp_rdata);
        if (w) begin
            check16("sram_lo", {8'h00, sram[a]}, {8'h00, ref_mem[a]});
            if (sz) check16("sram_hi", {8'h00, sram[a1]}, {8'h00, ref_mem[a1]});
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          ackc;
        logic        rw, rsz;
        logic [15:0] ra, rd;
        n_compared   = 0;
        n_mismatched = 0;
        exp_rdata    = 16'h0000;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);

        // reset
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 1'b0;
        addr = 16'h0000; wdata = 16'h0000; ext_wait = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check1("rst_busy", busy, 1'b0);
        check1("rst_ack", ack, 1'b0);
        check1("rst_oe_n", xcvr_oe_n, 1'b1);
        check1("rst_rd_n", ext_rd_n, 1'b1);
        check1("rst_wr_n", ext_wr_n, 1'b1);
        check1("rst_dir", xcvr_dir, 1'b0);
        check1("rst_a_drv", xcvr_a_drv, 1'b0);
        check16("rst_ext_addr", ext_addr, 16'h0000);
        check16("rst_rdata", rdata, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        fork
            monitor();
        join_none

        // byte write
        access(1'b1, SIZE_BYTE, 16'h1234, 16'h00A5, 0, 0, ackc);
        check_int("byte_write_ack_cycle", ackc, 5);
        check16("byte_write_sram", {8'h00, sram[16'h1234]}, 16'h00A5);

        // word read
        access(1'b0, SIZE_WORD, 16'h2000, 16'h0000, 0, 0, ackc);
        check_int("word_read_ack_cycle", ackc, 10);
        check16("word_read_data", rdata, 16'h7E3C);

        // address wrap on the second byte
        access(1'b1, SIZE_WORD, 16'hFFFF, 16'hBEEF, 0, 0, ackc);
        check16("wrap_sram_ffff", {8'h00, sram[16'hFFFF]}, 16'h00EF);
        check16("wrap_sram_0000", {8'h00, sram[16'h0000]}, 16'h00BE);

        // ext_wait stretch
        access(1'b0, SIZE_BYTE, 16'h1234, 16'h0000, 3, 0, ackc);
        check_int("wait_ack_cycle", ackc, 8);
        check16("wait_read_data", rdata, 16'h00A5);

        // direction turnaround
        access(1'b1, SIZE_BYTE, 16'h0010, 16'h0055, 0, 0, ackc);
        access(1'b0, SIZE_BYTE, 16'h0010, 16'h0000, 0, 0, ackc);
        check16("turnaround_read", rdata, 16'h0055);

        // reset during ACTIVE of a word write
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = SIZE_WORD; addr = 16'h4000; wdata = 16'h1357;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #10 rst = 1'b1;
        #1;
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_ack", ack, 1'b0);
        check1("midrst_oe_n", xcvr_oe_n, 1'b1);
        check1("midrst_rd_n", ext_rd_n, 1'b1);
        check1("midrst_wr_n", ext_wr_n, 1'b1);
        check1("midrst_a_drv", xcvr_a_drv, 1'b0);
        check16("midrst_rdata", rdata, 16'h0000);
        exp_rdata = 16'h0000;
        @(posedge clk);
        #10 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check1("post_rst_no_ack", ack, 1'b0);
            check1("post_rst_idle", busy, 1'b0);
        end
        check16("midrst_no_write", {8'h00, sram[16'h4000]}, {8'h00, ref_mem[16'h4000]});
        access(1'b1, SIZE_WORD, 16'h4000, 16'h1357, 0, 0, ackc);
        check_int("post_rst_write_ack_cycle", ackc, 10);
        access(1'b0, SIZE_WORD, 16'h4000, 16'h0000, 0, 0, ackc);
        check16("post_rst_read", rdata, 16'h1357);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            rw  = 1'($urandom_range(0, 1));
            rsz = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 3) == 0) ? (16'hFFFF - 16'($urandom_range(0, 1))) : 16'($urandom);
            rd  = 16'($urandom);
            access(rw, rsz, ra, rd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ackc);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/xbus_ctrl.md
Name: xbus_ctrl

Overview:
- Sequences CPU memory requests onto the 8-bit external data bus through one SN74LVC245 transceiver.
- Drives the transceiver's DIR and OE, the external address, and the RD/WR strobes.
- Splits 16-bit accesses into two byte cycles and returns a one-cycle ack to the core.
- Transceiver A side is the controller-local data bus; B side is the external memory bus.

Parameters:
- WAIT_CYCLES, 1: extra ACTIVE cycles beyond the mandatory one (range 0..15).
- TURN_CYCLES, 1: cycles with OE high after each byte before the bus may change (range 1..7).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  1  access request, sampled only in IDLE
- we  in  1  1 = write, 0 = read
- size  in  1  0 = byte, 1 = word (little-endian)
- addr  in  16  byte address
- wdata  in  16  write data (byte access uses [7:0])
- rdata  out  16  read data, registered
- ack  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- ext_addr  out  16  external address
- ext_rd_n  out  1  read strobe, active low
- ext_wr_n  out  1  write strobe, active low
- ext_wait  in  1  memory stretch request, synchronous to clk
- xcvr_dir  out  1  to 245 DIR: 1 = A→B (write), 0 = B→A (read)
- xcvr_oe_n  out  1  to 245 OE, active low
- xcvr_a_out  out  8  local-side write byte
- xcvr_a_drv  out  1  local-side tristate enable for xcvr_a_out
- xcvr_a_in  in  8  local-side read byte

Behaviour:
- Reset (async, immediate, also mid-access):
  - xcvr_oe_n=1, ext_rd_n=1, ext_wr_n=1, xcvr_dir=0, xcvr_a_drv=0.
  - ack=0, busy=0, rdata=0, ext_addr=0.
  - State goes to IDLE; any in-flight access is discarded and produces no ack.
- States: IDLE, SETUP, ACTIVE, HOLD, TURN.
- IDLE:
  - On a clk edge with req=1, latch we/size/addr/wdata, set byte index=0, go to SETUP.
  - req outside IDLE is ignored.
- SETUP (1 cycle):
  - ext_addr = latched addr + byte index, mod 2^16 (0xFFFF+1 wraps to 0x0000).
  - xcvr_dir = we. OE stays high.
  - Write: xcvr_a_drv=1, xcvr_a_out = wdata byte[index].
- ACTIVE (1+WAIT_CYCLES cycles minimum):
  - xcvr_oe_n=0.
  - ext_rd_n=0 if read; ext_wr_n=0 if write.
  - At the final counted edge, if ext_wait=1, remain in ACTIVE and re-sample next edge.
  - On the exit edge of a read, capture xcvr_a_in into rdata[8*index +: 8].
  - On a byte read, rdata[15:8] is cleared to 0 at that same edge.
- HOLD (1 cycle):
  - Strobes deasserted; OE stays low; addr, dir and write data held (hold time).
- TURN (TURN_CYCLES):
  - xcvr_oe_n=1, xcvr_a_drv=0; xcvr_dir is unchanged.
  - Last TURN cycle, word access with index=0: set index=1, go to SETUP.
  - Last TURN cycle, otherwise: ack=1 for that cycle, then IDLE.
- Invariants:
  - xcvr_dir never changes while xcvr_oe_n=0.
  - xcvr_a_drv=1 never coincides with a read.
  - ext_rd_n and ext_wr_n are never both low.
- Latency, byte access with defaults (acceptance edge E0):
  - SETUP [E0,E1), ACTIVE [E1,E3), HOLD [E3,E4), TURN [E4,E5) with ack high; IDLE from E5.
- Word access: two back-to-back byte sequences, 10 cycles, ack in cycle 10.
- ext_wait adds one cycle per high sample.
- rdata holds its value until the next read capture.

Decomposition:
- Package xbus_pkg:
  - state enum.
  - DIR_A2B=1, DIR_B2A=0.
  - SIZE_BYTE=0, SIZE_WORD=1.
- Sub-module xbus_wait_ctr: loadable down-counter for ACTIVE/TURN length. Everything else stays in xbus_ctrl.

Test Plan:
- Bench setup: clk period 50 ns, with an SN74LVC245 instance (TEN=8) and an 8-bit SRAM model on B.
- Byte write: req, we=1, size=0, addr=0x1234, wdata=0x00A5.
  - SRAM[0x1234]=0xA5.
  - ack in cycle 5.
  - xcvr_dir=1 throughout; OE low only in ACTIVE/HOLD.
- Word read: SRAM[0x2000]=0x3C, SRAM[0x2001]=0x7E.
  - rdata=0x7E3C, ack in cycle 10.
  - xcvr_dir=0; A side never driven by the controller.
- Wrap: word write at 0xFFFF, wdata=0xBEEF.
  - SRAM[0xFFFF]=0xEF, SRAM[0x0000]=0xBE.
- Wait stretch: byte read with ext_wait high for 3 ACTIVE edges.
  - ACTIVE lasts 5 cycles; ack in cycle 8; correct data.
- Direction turnaround: write 0x55 to 0x10, then immediately read 0x10.
  - Read returns 0x55.
  - Assertion: DIR never toggles while OE low; no bus contention (no X on A/B).
- Reset mid-ACTIVE of a word write:
  - All strobes/OE high and busy=0 within the same time step.
  - No ack.
  - Next req is accepted normally.
